// File: rtl/bcd_scan_ctrl.sv
// BCD digit sequencer driving a bddec decoder: timed stepping with run/stop, direction and load.
// Define BCD_SCAN_CHECK_EN to compare the decoder's one-hot return against the current digit.
module bcd_scan_ctrl #(
  parameter int         DWELL_W   = 8,
  parameter logic [3:0] RST_DIGIT = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               up,
  input  logic               load,
  input  logic [3:0]         load_val,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a0,
  output logic               a1,
  output logic               a2,
  output logic               a3,
  input  logic [9:0]         dec_in,
  output logic [3:0]         digit,
  output logic               busy,
  output logic               step,
  output logic               wrap,
  output logic               load_bad,
  output logic               err,
  output logic [3:0]         err_digit
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] lim_m1;
  logic               load_ok;
  logic               at_end;

  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic dir_up);
    if (dir_up) return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else        return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic wraps(input logic [3:0] d, input logic dir_up);
    return dir_up ? (d >= 4'd9) : (d == 4'd0);
  endfunction

  // A dwell of 0 behaves as 1; ">=" makes a shrunk dwell advance on the next cycle.
  assign lim_m1  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign at_end  = (cnt >= lim_m1);
  assign load_ok = load && (load_val <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      digit    <= RST_DIGIT;
      cnt      <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      load_bad <= 1'b0;
    end else begin
      step     <= 1'b0;
      wrap     <= 1'b0;
      load_bad <= load && (load_val > 4'd9);
      if (load_ok) begin
        digit <= load_val;
        cnt   <= '0;
      end else if (stop) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          cnt   <= '0;
        end
      end else if (at_end) begin
        cnt   <= '0;
        digit <= next_digit(digit, up);
        step  <= 1'b1;
        wrap  <= wraps(digit, up);
      end else begin
        cnt <= cnt + DWELL_W'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign a0   = digit[3];
  assign a1   = digit[2];
  assign a2   = digit[1];
  assign a3   = digit[0];

`ifdef BCD_SCAN_CHECK_EN
  logic [9:0] exp_onehot;
  assign exp_onehot = 10'd1 << digit;

  // First mismatch is latched; later ones are ignored until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_digit <= 4'd0;
    end else if (!err && (dec_in != exp_onehot)) begin
      err       <= 1'b1;
      err_digit <= digit;
    end
  end
`else
  logic unused_dec;
  assign unused_dec = ^dec_in;
  assign err        = 1'b0;
  assign err_digit  = 4'd0;
`endif

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Sequencer for the 4-bit BCD-to-decimal decoder (bddec). Steps a registered BCD digit 0..9 onto the decoder inputs a0..a3, holding each digit for a programmable number of clock cycles. Supports run/stop, count direction and a synchronous load. Optionally checks the decoder's one-hot d0..d9 return against the expected pattern for every digit.

Parameters:
DWELL_W, 8, width of dwell count input.
RST_DIGIT, 4'd0, digit value loaded at reset; must be 0..9.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse: begin stepping.
stop  input  1  pulse: halt stepping, digit held.
up  input  1  level: 1 = count up, 0 = count down; sampled at each step.
load  input  1  pulse: load load_val into digit.
load_val  input  4  value for load; 10..15 rejected.
dwell  input  DWELL_W  cycles per digit; 0 treated as 1.
a0  output  1  decoder input, digit bit 3 (MSB).
a1  output  1  decoder input, digit bit 2.
a2  output  1  decoder input, digit bit 1.
a3  output  1  decoder input, digit bit 0 (LSB).
dec_in  input  10  decoder outputs; dec_in[k] = dk, active-high one-hot.
digit  output  4  current digit, equal to {a0,a1,a2,a3}.
busy  output  1  1 while in RUN.
step  output  1  1-cycle pulse in the cycle the new digit first appears.
wrap  output  1  1-cycle pulse with step on a 9->0 (up) or 0->9 (down) transition.
load_bad  output  1  1-cycle pulse when load is asserted with load_val > 9.
err  output  1  sticky decoder mismatch flag (check feature only).
err_digit  output  4  digit at the first mismatch (check feature only).

Behaviour:
- Reset (async, rst_n=0): state IDLE; digit=RST_DIGIT; dwell counter=0; busy, step, wrap, load_bad, err = 0; err_digit=0.
- All outputs are registered. a0..a3 mirror the digit register with no extra latency.
- States:
  - IDLE: digit held. start -> RUN.
  - RUN: dwell counter increments each cycle. When it reaches max(dwell,1)-1, it returns to 0 and the digit advances on the next edge.
    - up=1: 9->0 wraps. up=0: 0->9 wraps.
    - step (and wrap, if applicable) is asserted in the cycle the new digit is visible.
    - stop -> IDLE.
- dwell=1 or dwell=0: digit advances every cycle while RUN; step stays high continuously.
- Priority within one cycle: load > stop > start.
  - start and stop together: stop wins; stay or return to IDLE.
- Load, valid (load_val 0..9), any state:
  - digit=load_val next cycle; dwell counter=0; state unchanged; no step or wrap pulse.
  - load in the same cycle as a scheduled advance: load wins; advance suppressed.
- Load, invalid (load_val 10..15): digit and counter unchanged; load_bad pulses 1 cycle.
- start while already in RUN: ignored; counter not cleared.
- dwell changed mid-digit: new value takes effect immediately. If the counter is already >= new max-1, the advance occurs on the next cycle.
- Reset asserted mid-RUN: immediate return to reset values; no pulse is completed.

Optional Feature:
BCD_SCAN_CHECK_EN.
- Defined:
  - Every cycle after reset release, compare dec_in with the expected one-hot (bit [digit] = 1, all others 0).
  - On the first mismatch: err <= 1 and err_digit <= digit. Both hold until reset; later mismatches do not overwrite them.
- Undefined: dec_in is ignored; err and err_digit are tied to 0; no compare logic is synthesized.

Test Plan:
- Reset, then start with dwell=3, up=1 -> digit sequence 0,0,0,1,1,1,2,... ; step pulses every 3 cycles; after digit 9, digit 0 appears with wrap=1.
- up=0, load_val=2, load, start, dwell=1 -> digits 2,1,0,9,8 on consecutive cycles; wrap only on the 0->9 cycle; step high throughout.
- In RUN, assert load with load_val=12 -> load_bad=1 for 1 cycle; digit and step cadence are unaffected.
- start and stop asserted in the same cycle from IDLE -> busy stays 0. Stop during RUN at digit 5 -> digit stays 5 and busy=0 on the next cycle.
- dwell=0 -> behaves identically to dwell=1. Assert rst_n=0 mid-dwell at digit 7 -> digit=0 and busy=0 immediately, with no clock edge required.
- With BCD_SCAN_CHECK_EN, drive a correct one-hot dec_in, then force dec_in=10'b0000001000 while digit=4 -> err=1 and err_digit=4, held after dec_in is corrected. Without the macro, err stays 0.
